// File: rtl/clocks_multiphase_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clocks_multiphase_if                                       |
// | Purpose : Control/status bundle between the multiphase clock         |
// |           generator (slave) and the controlling logic (master).      |
// | Options : STRETCH_EN adds the stretch wait-state request.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface clocks_multiphase_if #(
  parameter int NPHASE = 4,
  parameter int QW     = 8
);
  localparam int SW = $clog2(NPHASE);

  logic [QW-1:0]     quarter_len;
  logic              run;
  logic              step;
`ifdef STRETCH_EN
  logic              stretch;
`endif
  logic              core_reset;
  logic [NPHASE-1:0] phase;
  logic [SW-1:0]     slot;
  logic              cycle_start;
  logic              halted;
  logic              step_done;

  modport master (
`ifdef STRETCH_EN
    output stretch,
`endif
    output quarter_len, run, step,
    input  core_reset, phase, slot, cycle_start, halted, step_done
  );

  modport slave (
`ifdef STRETCH_EN
    input  stretch,
`endif
    input  quarter_len, run, step,
    output core_reset, phase, slot, cycle_start, halted, step_done
  );
endinterface
`default_nettype wire

// File: rtl/clocks_multiphase.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clocks_multiphase                                          |
// | Purpose : Divides eclk into an NPHASE-slot machine cycle with a      |
// |           one-hot registered phase vector, programmable slot length, |
// |           power-on core_reset stretch and run/halt/step control.     |
// | Options : define STRETCH_EN to add bus.stretch (wait-state insert).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clocks_multiphase #(
  parameter int NPHASE       = 4,
  parameter int QW           = 8,
  parameter int QDEFAULT     = 8,
  parameter int RW           = 20,
  parameter int RESET_CYCLES = 700000
) (
  input  wire logic          eclk,
  input  wire logic          ereset_n,
  clocks_multiphase_if.slave bus
);
  localparam int              SW        = $clog2(NPHASE);
  localparam logic [RW-1:0]   RC_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(NPHASE - 1);
  localparam logic [QW-1:0]   QLEN_RST  = QW'(QDEFAULT);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  logic [RW-1:0]     rc_q, rc_d;
  logic              core_reset_q, core_reset_d;
  logic [QW-1:0]     q_q, q_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [QW-1:0]     qlen_q, qlen_d;
  logic [1:0]        state_q, state_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic              cycle_start_q, cycle_start_d;
  logic              halted_q, halted_d;
  logic              step_done_q, step_done_d;

  logic              w_stretch;
  logic              w_q_last;
  logic              w_adv;
  logic              w_boundary;
  logic              w_start;
  logic [NPHASE-1:0] w_onehot;

`ifdef STRETCH_EN
  assign w_stretch = bus.stretch;
`else
  assign w_stretch = 1'b0;
`endif

  // One-hot decode of the next slot index
  for (genvar i = 0; i < NPHASE; i++) begin : g_phase_dec
    assign w_onehot[i] = (slot_d == SW'(i));
  end

  // Next-state logic: reset stretch, slot/quarter counters and run/halt/step FSM
  always_comb begin
    rc_d         = (rc_q == RC_LAST) ? rc_q : rc_q + 1'b1;
    core_reset_d = core_reset_q & (rc_q != RC_LAST);

    w_q_last   = (q_q == qlen_q - 1'b1);
    w_adv      = w_q_last & ~w_stretch;
    w_boundary = w_adv & (slot_q == SLOT_LAST);

    state_d     = state_q;
    q_d         = q_q;
    slot_d      = slot_q;
    qlen_d      = qlen_q;
    step_done_d = 1'b0;
    w_start     = 1'b0;

    case (state_q)
      S_HALT: begin
        // Counters stay parked at slot 0 / q 0; run has priority over step
        if (bus.run) begin
          state_d = S_RUN;
          w_start = 1'b1;
        end else if (bus.step) begin
          state_d = S_STEP;
          w_start = 1'b1;
        end
      end
      default: begin
        // Unused encoding recovers into RUN
        state_d = (state_q == S_STEP) ? S_STEP : S_RUN;
        if (w_adv) begin
          q_d    = '0;
          slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else if (!w_q_last) begin
          q_d = q_q + 1'b1;
        end
        if (w_boundary) begin
          // Slot length only changes between machine cycles
          qlen_d  = (bus.quarter_len == '0) ? QW'(1) : bus.quarter_len;
          w_start = 1'b1;
          if (state_q == S_STEP) begin
            state_d     = S_HALT;
            step_done_d = 1'b1;
            w_start     = 1'b0;
          end else if (!bus.run && !core_reset_q) begin
            // The core is never halted while it is still held in reset
            state_d = S_HALT;
            w_start = 1'b0;
          end
        end
      end
    endcase

    cycle_start_d = w_start;
    halted_d      = (state_d == S_HALT);
    phase_d       = halted_d ? '0 : w_onehot;
  end

  // State and registered outputs, asynchronously reset
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      rc_q          <= '0;
      core_reset_q  <= 1'b1;
      q_q           <= '0;
      slot_q        <= '0;
      qlen_q        <= QLEN_RST;
      state_q       <= S_RUN;
      phase_q       <= NPHASE'(1);
      cycle_start_q <= 1'b0;
      halted_q      <= 1'b0;
      step_done_q   <= 1'b0;
    end else begin
      rc_q          <= rc_d;
      core_reset_q  <= core_reset_d;
      q_q           <= q_d;
      slot_q        <= slot_d;
      qlen_q        <= qlen_d;
      state_q       <= state_d;
      phase_q       <= phase_d;
      cycle_start_q <= cycle_start_d;
      halted_q      <= halted_d;
      step_done_q   <= step_done_d;
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.phase       = phase_q;
  assign bus.slot        = slot_q;
  assign bus.cycle_start = cycle_start_q;
  assign bus.halted      = halted_q;
  assign bus.step_done   = step_done_q;
endmodule
`default_nettype wire

// File: tb/tb_clocks_multiphase.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_clocks_multiphase                                       |
// | Purpose : Directed self-checking bench for clocks_multiphase.        |
// |           Build with STRETCH_EN defined to exercise stretch.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_clocks_multiphase;
  localparam int NPHASE = 4;
  localparam int QW     = 8;

  logic eclk     = 1'b0;
  logic ereset_n = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  clocks_multiphase_if #(.NPHASE(NPHASE), .QW(QW)) bus  ();
  clocks_multiphase_if #(.NPHASE(NPHASE), .QW(QW)) bus2 ();

  // Main instance: 3-eclk slots, 10-cycle reset stretch
  clocks_multiphase #(.NPHASE(NPHASE), .QW(QW), .QDEFAULT(3), .RW(20), .RESET_CYCLES(10)) u_dut (
    .eclk(eclk), .ereset_n(ereset_n), .bus(bus)
  );

  // Second instance: 1-eclk slots, run held low, so boundaries occur while core_reset is high
  clocks_multiphase #(.NPHASE(NPHASE), .QW(QW), .QDEFAULT(1), .RW(20), .RESET_CYCLES(10)) u_dut2 (
    .eclk(eclk), .ereset_n(ereset_n), .bus(bus2)
  );

  always #5 eclk = ~eclk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge eclk);
      #1;
    end
  endtask

  // Edges until the next cycle_start, or -1 when the budget expires
  task automatic wait_cs(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge eclk);
      #1;
      if (bus.cycle_start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 ereset_n = 1'b0;
    #10;
    n_cmp++; if (bus.core_reset !== 1'b1) begin n_bad++; $display("FAIL reset_core_reset: got %b want 1", bus.core_reset); end
    n_cmp++; if (bus.phase !== 4'b0001) begin n_bad++; $display("FAIL reset_phase: got %b want 0001", bus.phase); end
    n_cmp++; if (bus.slot !== 2'd0) begin n_bad++; $display("FAIL reset_slot: got %0d want 0", bus.slot); end
    n_cmp++; if (bus.cycle_start !== 1'b0) begin n_bad++; $display("FAIL reset_cycle_start: got %b want 0", bus.cycle_start); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    n_cmp++; if (bus.step_done !== 1'b0) begin n_bad++; $display("FAIL reset_step_done: got %b want 0", bus.step_done); end
    @(negedge eclk);
    ereset_n = 1'b1;
  endtask

  task automatic test_reset_stretch();
    logic [3:0] exp_ph;
    logic [3:0] exp_ph2;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      exp_ph  = 4'b0001 << ((k / 3) % 4);
      exp_ph2 = (k == 12) ? 4'b0000 : 4'b0001 << (k % 4);
      n_cmp++; if (bus.core_reset !== 1'(k < 10)) begin n_bad++; $display("FAIL stretch_core_reset k=%0d: got %b want %b", k, bus.core_reset, 1'(k < 10)); end
      n_cmp++; if (bus.phase !== exp_ph) begin n_bad++; $display("FAIL seq_phase k=%0d: got %b want %b", k, bus.phase, exp_ph); end
      n_cmp++; if (bus.cycle_start !== 1'(k == 12)) begin n_bad++; $display("FAIL seq_cycle_start k=%0d: got %b want %b", k, bus.cycle_start, 1'(k == 12)); end
      n_cmp++; if (bus2.phase !== exp_ph2) begin n_bad++; $display("FAIL rst_run_phase k=%0d: got %b want %b", k, bus2.phase, exp_ph2); end
      n_cmp++; if (bus2.halted !== 1'(k == 12)) begin n_bad++; $display("FAIL rst_run_halted k=%0d: got %b want %b", k, bus2.halted, 1'(k == 12)); end
    end
  endtask

  task automatic test_quarter_len();
    int n;
    tick(4);
    bus.quarter_len = 8'd5;
    wait_cs(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL qlen_current_cycle: got %0d want 8 remaining", n); end
    wait_cs(n);
    n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL qlen5_cycle: got %0d want 20", n); end
    bus.quarter_len = 8'd0;
    wait_cs(n);
    n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL qlen0_pending_cycle: got %0d want 20", n); end
    wait_cs(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL qlen0_cycle: got %0d want 4", n); end
    bus.quarter_len = 8'd3;
    tick(1);
    n_cmp++; if (bus.phase !== 4'b0010) begin n_bad++; $display("FAIL qlen0_ph1: got %b want 0010", bus.phase); end
    tick(1);
    n_cmp++; if (bus.phase !== 4'b0100) begin n_bad++; $display("FAIL qlen0_ph2: got %b want 0100", bus.phase); end
    tick(1);
    n_cmp++; if (bus.phase !== 4'b1000) begin n_bad++; $display("FAIL qlen0_ph3: got %b want 1000", bus.phase); end
    tick(1);
    n_cmp++; if (bus.cycle_start !== 1'b1 || bus.phase !== 4'b0001) begin n_bad++; $display("FAIL qlen0_wrap: got cs=%b ph=%b want cs=1 ph=0001", bus.cycle_start, bus.phase); end
    wait_cs(n);
    n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL qlen3_restore: got %0d want 12", n); end
  endtask

  task automatic test_halt();
    int n;
    tick(7);
    bus.run = 1'b0;
    for (int e = 8; e <= 11; e++) begin
      tick(1);
      n_cmp++; if (bus.phase !== ((e == 8) ? 4'b0100 : 4'b1000) || bus.halted !== 1'b0) begin n_bad++; $display("FAIL halt_finish e=%0d: got ph=%b h=%b", e, bus.phase, bus.halted); end
    end
    tick(1);
    n_cmp++; if (bus.phase !== 4'b0000 || bus.halted !== 1'b1 || bus.cycle_start !== 1'b0 || bus.slot !== 2'd0) begin n_bad++; $display("FAIL halt_enter: got ph=%b h=%b cs=%b slot=%0d want 0000/1/0/0", bus.phase, bus.halted, bus.cycle_start, bus.slot); end
    tick(3);
    n_cmp++; if (bus.phase !== 4'b0000 || bus.halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold: got ph=%b h=%b want 0000/1", bus.phase, bus.halted); end
    bus.run = 1'b1;
    tick(1);
    n_cmp++; if (bus.phase !== 4'b0001 || bus.cycle_start !== 1'b1 || bus.halted !== 1'b0) begin n_bad++; $display("FAIL halt_resume: got ph=%b cs=%b h=%b want 0001/1/0", bus.phase, bus.cycle_start, bus.halted); end
    wait_cs(n);
    n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL halt_resume_len: got %0d want 12", n); end
  endtask

  task automatic test_step();
    int sd;
    bus.run = 1'b0;
    tick(12);
    n_cmp++; if (bus.halted !== 1'b1) begin n_bad++; $display("FAIL step_pre_halt: got %b want 1", bus.halted); end
    tick(2);
    bus.step = 1'b1;
    tick(1);
    n_cmp++; if (bus.cycle_start !== 1'b1 || bus.halted !== 1'b0 || bus.phase !== 4'b0001) begin n_bad++; $display("FAIL step_start: got cs=%b h=%b ph=%b", bus.cycle_start, bus.halted, bus.phase); end
    bus.step = 1'b0;
    sd = 0;
    for (int i = 1; i <= 11; i++) begin
      tick(1);
      if (bus.step_done === 1'b1 || bus.halted === 1'b1) sd++;
    end
    n_cmp++; if (sd !== 0) begin n_bad++; $display("FAIL step_early_end: got %0d early done/halt cycles want 0", sd); end
    tick(1);
    n_cmp++; if (bus.step_done !== 1'b1 || bus.halted !== 1'b1 || bus.phase !== 4'b0000) begin n_bad++; $display("FAIL step_end: got sd=%b h=%b ph=%b want 1/1/0000", bus.step_done, bus.halted, bus.phase); end
    tick(1);
    n_cmp++; if (bus.step_done !== 1'b0 || bus.halted !== 1'b1) begin n_bad++; $display("FAIL step_after: got sd=%b h=%b want 0/1", bus.step_done, bus.halted); end
  endtask

  task automatic test_back_to_back();
    bus.step = 1'b1;
    tick(12);
    tick(1);
    n_cmp++; if (bus.step_done !== 1'b1 || bus.halted !== 1'b1) begin n_bad++; $display("FAIL b2b_first_end: got sd=%b h=%b want 1/1", bus.step_done, bus.halted); end
    tick(1);
    n_cmp++; if (bus.halted !== 1'b0 || bus.cycle_start !== 1'b1) begin n_bad++; $display("FAIL b2b_reenter: got h=%b cs=%b want 0/1", bus.halted, bus.cycle_start); end
    bus.step = 1'b0;
    tick(12);
    n_cmp++; if (bus.step_done !== 1'b1 || bus.halted !== 1'b1) begin n_bad++; $display("FAIL b2b_second_end: got sd=%b h=%b want 1/1", bus.step_done, bus.halted); end
  endtask

  task automatic test_run_step_together();
    int sd;
    bus.run  = 1'b1;
    bus.step = 1'b1;
    tick(1);
    n_cmp++; if (bus.cycle_start !== 1'b1 || bus.halted !== 1'b0) begin n_bad++; $display("FAIL runstep_start: got cs=%b h=%b want 1/0", bus.cycle_start, bus.halted); end
    bus.step = 1'b0;
    sd = 0;
    for (int i = 1; i <= 11; i++) begin
      tick(1);
      if (bus.step_done === 1'b1) sd++;
    end
    tick(1);
    n_cmp++; if (bus.cycle_start !== 1'b1 || bus.halted !== 1'b0 || bus.step_done !== 1'b0 || sd !== 0) begin n_bad++; $display("FAIL runstep_boundary: got cs=%b h=%b sd=%b early=%0d want 1/0/0/0", bus.cycle_start, bus.halted, bus.step_done, sd); end
  endtask

`ifdef STRETCH_EN
  task automatic test_stretch();
    int n;
    tick(5);
    n_cmp++; if (bus.phase !== 4'b0010) begin n_bad++; $display("FAIL stretch_pre: got %b want 0010", bus.phase); end
    bus.stretch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_cmp++; if (bus.phase !== 4'b0010) begin n_bad++; $display("FAIL stretch_hold i=%0d: got %b want 0010", i, bus.phase); end
    end
    bus.stretch = 1'b0;
    tick(1);
    n_cmp++; if (bus.phase !== 4'b0100) begin n_bad++; $display("FAIL stretch_release: got %b want 0100", bus.phase); end
    wait_cs(n);
    n_cmp++; if (10 + n !== 16) begin n_bad++; $display("FAIL stretch_cycle_len: got %0d want 16", 10 + n); end
  endtask
`endif

  task automatic test_async_reset();
    bus.run = 1'b0;
    tick(12);
    n_cmp++; if (bus.halted !== 1'b1) begin n_bad++; $display("FAIL areset_pre_halt: got %b want 1", bus.halted); end
    bus.step = 1'b1;
    tick(1);
    bus.step = 1'b0;
    tick(5);
    #2 ereset_n = 1'b0;
    #1;
    n_cmp++; if (bus.core_reset !== 1'b1 || bus.phase !== 4'b0001 || bus.slot !== 2'd0) begin n_bad++; $display("FAIL areset_vals: got cr=%b ph=%b slot=%0d want 1/0001/0", bus.core_reset, bus.phase, bus.slot); end
    n_cmp++; if (bus.cycle_start !== 1'b0 || bus.halted !== 1'b0 || bus.step_done !== 1'b0) begin n_bad++; $display("FAIL areset_flags: got cs=%b h=%b sd=%b want 0/0/0", bus.cycle_start, bus.halted, bus.step_done); end
    bus.run = 1'b1;
    @(negedge eclk);
    ereset_n = 1'b1;
    tick(3);
    n_cmp++; if (bus.core_reset !== 1'b1 || bus.phase !== 4'b0010 || bus.halted !== 1'b0) begin n_bad++; $display("FAIL areset_restart: got cr=%b ph=%b h=%b want 1/0010/0", bus.core_reset, bus.phase, bus.halted); end
  endtask

  initial begin
    bus.quarter_len  = 8'd3;
    bus.run          = 1'b1;
    bus.step         = 1'b0;
    bus2.quarter_len = 8'd1;
    bus2.run         = 1'b0;
    bus2.step        = 1'b0;
`ifdef STRETCH_EN
    bus.stretch      = 1'b0;
    bus2.stretch     = 1'b0;
`endif
    test_reset();
    test_reset_stretch();
    test_quarter_len();
    test_halt();
    test_step();
    test_back_to_back();
    test_run_step_together();
`ifdef STRETCH_EN
    test_stretch();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget (compared %0d, mismatched %0d)", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/clocks_multiphase.md
Name: clocks_multiphase

Overview:
Parametrised successor of the 4004 clock/reset generator. Divides eclk into an NPHASE-slot machine cycle with a one-hot registered phase vector, runtime-programmable slot length, and a power-on core_reset stretch. Adds run/halt/single-step control for bring-up of any netlist core (4004, 8008, ...) on FPGA. Sits between the board clock/reset and the core's clk inputs.

Parameters:
NPHASE, 4, slots per machine cycle (>=2); 4004 uses clk1=phase[0], clk2=phase[2]
QW, 8, width of slot-length counter and quarter_len
QDEFAULT, 8, slot length in eclk cycles loaded at reset (1..2^QW-1)
RW, 20, width of reset-stretch counter
RESET_CYCLES, 700000, eclk cycles core_reset is held after ereset_n release (<2^RW)

Ports:
eclk  in  1  system clock, all flops rising-edge
ereset_n  in  1  asynchronous active-low reset
quarter_len  in  QW  requested slot length in eclk cycles; 0 treated as 1
run  in  1  1 = free-run, 0 = halt at next machine-cycle boundary
step  in  1  in HALT, request exactly one machine cycle
core_reset  out  1  reset to core, active high
phase  out  NPHASE  one-hot current slot, all-zero when halted
slot  out  clog2(NPHASE)  current slot index
cycle_start  out  1  one-eclk pulse on first eclk of slot 0
halted  out  1  FSM in HALT
step_done  out  1  one-eclk pulse when a STEP cycle finishes

Behaviour:
- ereset_n low (async): rc=0, q=0, slot=0, qlen=QDEFAULT, state=RUN, core_reset=1, phase=1 (slot 0), cycle_start=0, halted=0, step_done=0.
- All outputs are flops; no combinational paths from inputs to outputs.
- Reset stretch: rc increments each eclk after release, saturates; core_reset falls on the edge where rc reaches RESET_CYCLES-1, i.e. high for exactly RESET_CYCLES eclk edges after release.
- Slot timing: q counts 0..qlen-1; at q==qlen-1, q<=0 and slot<=(slot+1) mod NPHASE. Each slot lasts exactly qlen eclk cycles.
- qlen reloads only at machine-cycle boundary (slot NPHASE-1, q==qlen-1): qlen<=max(quarter_len,1). Mid-cycle changes never alter the current cycle.
- cycle_start registered high for the single eclk cycle in which slot==0 and q==0 while not halted.
- FSM states RUN, HALT, STEP:
  RUN: at boundary, if run==0 and core_reset==0 -> HALT (slot=0, q=0, phase=0, halted=1); else continue into slot 0.
  HALT: counters frozen. run==1 -> RUN, slot 0 starts next eclk with cycle_start. run==0 & step==1 -> STEP, same start. run and step together: run wins.
  STEP: one full machine cycle, then HALT at boundary regardless of run; step_done pulses on that boundary edge. step held high re-enters STEP only after one HALT cycle (edge-free level; one cycle per HALT visit).
- step ignored in RUN/STEP. While core_reset==1, run is ignored (core always clocked during reset).
- ereset_n assertion mid-cycle or mid-STEP aborts immediately to reset values.

Optional Feature:
STRETCH_EN: adds input port stretch (1 bit). When defined and stretch==1, q holds at qlen-1 (current slot extended, phase unchanged) until stretch==0; wait-state insertion for slow external memory. Boundary/qlen reload occurs on the edge that finally advances. Without the macro: no port, behaviour as stretch==0.

Test Plan:
RESET_CYCLES=10, QDEFAULT=3, NPHASE=4; release ereset_n -> core_reset high for 10 edges, phase sequence 0001,0010,0100,1000 each 3 eclk, cycle_start every 12 eclk.
quarter_len=5 written during slot 1 -> current cycle stays 12 eclk, next cycle 20 eclk; quarter_len=0 -> slots of 1 eclk (4-eclk cycle).
run=0 mid-slot 2 after core_reset low -> phase completes slot 3, then phase=0000, halted=1; run=1 -> next eclk phase=0001 with cycle_start.
In HALT pulse step -> exactly one 12-eclk cycle, step_done one pulse at end, halted=1 again; run&step together -> RUN, no step_done.
run=0 while core_reset high -> clocks continue; halt only takes effect at first boundary after core_reset falls.
STRETCH_EN: stretch high 4 eclk during slot 1 -> slot 1 lasts 7 eclk, cycle 16 eclk; ereset_n pulse mid-STEP -> all outputs at reset values asynchronously.
